freq_divider_prog: RTL

Parametrised, runtime-programmable clock-enable generator replacing the fixed 100 MHz-to-1 Hz divider. It produces a divided square wave with programmable period and high time, plus a one-cycle tick strobe per period. New divisor settings are loaded through a pulse interface and take effect glitch-free at the period boundary. Display timing, blink and seconds logic use it in the 100 MHz domain.

---
 rtl/freq_divider_prog.sv | 139 +++++++++++++
 1 files changed

// File: rtl/freq_divider_prog.sv
// Runtime-programmable clock-enable generator: divided square wave, period tick,
// and glitch-free divisor reload. Optional macro FREQ_DIV_IMMEDIATE_LOAD_EN applies loads at once.
module freq_divider_prog #(
  parameter int WIDTH        = 27,
  parameter int DEFAULT_DIV  = 100000000,
  parameter int DEFAULT_HIGH = 50000000
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] counter,
  output logic             load_ack,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

  logic [WIDTH-1:0] counter_r, div_act_r, high_act_r, div_pend_r, high_pend_r;
  logic             pend_valid_r, clk_out_r, at_last_r, load_ack_r, load_err_r;
  logic [WIDTH-1:0] counter_nx_s, div_nx_s, high_nx_s, div_pend_nx_s, high_pend_nx_s;
  logic             pend_valid_nx_s, ack_nx_s, err_nx_s, load_ok_s, wrap_s;
`ifdef FREQ_DIV_IMMEDIATE_LOAD_EN
  logic             imm_ack_r;
`endif

  function automatic logic load_valid(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] h);
    return (d >= TWO) && (h >= ONE) && (h <= d - ONE);
  endfunction

  // Next-state computation for phase counter, active and pending settings.
  always_comb begin
    load_ok_s       = load && load_valid(div_in, high_in);
    err_nx_s        = load && !load_valid(div_in, high_in);
    wrap_s          = en && (counter_r == div_act_r - ONE);
    counter_nx_s    = counter_r;
    div_nx_s        = div_act_r;
    high_nx_s       = high_act_r;
    div_pend_nx_s   = div_pend_r;
    high_pend_nx_s  = high_pend_r;
    pend_valid_nx_s = pend_valid_r;
    ack_nx_s        = 1'b0;

    if (wrap_s) begin
      counter_nx_s = '0;
      if (pend_valid_r) begin
        div_nx_s        = div_pend_r;
        high_nx_s       = high_pend_r;
        pend_valid_nx_s = 1'b0;
        ack_nx_s        = 1'b1;
      end else begin
        ack_nx_s = 1'b0;
      end
    end else if (en) begin
      counter_nx_s = counter_r + ONE;
    end else begin
      counter_nx_s = counter_r;
    end

`ifdef FREQ_DIV_IMMEDIATE_LOAD_EN
    // A valid load overrides a coincident wrap and restarts the period.
    if (load_ok_s) begin
      div_nx_s        = div_in;
      high_nx_s       = high_in;
      counter_nx_s    = '0;
      pend_valid_nx_s = 1'b0;
      ack_nx_s        = 1'b0;
    end else begin
      div_pend_nx_s = div_pend_r;
    end
`else
    // Applied after the wrap so a coincident load waits for the following wrap.
    if (load_ok_s) begin
      div_pend_nx_s   = div_in;
      high_pend_nx_s  = high_in;
      pend_valid_nx_s = 1'b1;
    end else begin
      div_pend_nx_s  = div_pend_r;
      high_pend_nx_s = high_pend_r;
    end
`endif
  end

  // State and registered outputs; clk_out/at_last are precomputed from next state.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      counter_r    <= '0;
      div_act_r    <= DIV_RST;
      high_act_r   <= HIGH_RST;
      div_pend_r   <= DIV_RST;
      high_pend_r  <= HIGH_RST;
      pend_valid_r <= 1'b0;
      clk_out_r    <= 1'b0;
      at_last_r    <= 1'b0;
      load_ack_r   <= 1'b0;
      load_err_r   <= 1'b0;
    end else begin
      counter_r    <= counter_nx_s;
      div_act_r    <= div_nx_s;
      high_act_r   <= high_nx_s;
      div_pend_r   <= div_pend_nx_s;
      high_pend_r  <= high_pend_nx_s;
      pend_valid_r <= pend_valid_nx_s;
      clk_out_r    <= (counter_nx_s >= (div_nx_s - high_nx_s));
      at_last_r    <= (counter_nx_s == (div_nx_s - ONE));
`ifdef FREQ_DIV_IMMEDIATE_LOAD_EN
      load_ack_r   <= ack_nx_s | imm_ack_r;
`else
      load_ack_r   <= ack_nx_s;
`endif
      load_err_r   <= err_nx_s;
    end
  end

`ifdef FREQ_DIV_IMMEDIATE_LOAD_EN
  // Delays the immediate-load acknowledge to the cycle after the counter restart.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      imm_ack_r <= 1'b0;
    end else begin
      imm_ack_r <= load_ok_s;
    end
  end
`endif

  assign counter  = counter_r;
  assign clk_out  = clk_out_r;
  assign tick     = at_last_r & en;
  assign load_ack = load_ack_r;
  assign load_err = load_err_r;

endmodule
